// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller.
// Adds two DIGITS-wide packed-BCD operands one decimal digit per clock,
// least-significant digit first, rippling the decimal carry between cycles.
// Valid/ready handshakes on both the operand and the result side.
// Also flags any operand digit above 9 (err).
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  // One decimal digit add with correction.
  // Returns {carry, digit}; raw sums above 9 are corrected by +6.
  // Non-BCD inputs follow the same rule so the result stays defined.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] x,
                                                input logic [3:0] y,
                                                input logic       c);
    logic [4:0] raw;
    logic [4:0] adj;
    raw = {1'b0, x} + {1'b0, y} + {4'b0000, c};
    adj = raw + 5'd6;
    if (raw > 5'd9) return {1'b1, adj[3:0]};
    else            return {1'b0, raw[3:0]};
  endfunction

  // True when any 4-bit digit of the packed operand exceeds 9.
  function automatic logic any_non_bcd(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [3:0]       a_dig;
  logic [3:0]       b_dig;
  logic [4:0]       add_res;
  logic             accept;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // clr takes priority over a pending operand handshake.
  assign accept = in_valid && in_ready && !clr;

  // Select the operand digits addressed by the running index.
  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_dig = a_r[4*i +: 4];
        b_dig = b_r[4*i +: 4];
      end
    end
    add_res = bcd_digit_add(a_dig, b_dig, carry);
  end

  // Operand capture: sampled only at accept, ignored afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= a;
      b_r <= b;
    end
  end

  // Control FSM, digit index, carry chain and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else if (clr) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_ADD;
            idx   <= '0;
            carry <= cin;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= any_non_bcd(a) | any_non_bcd(b);
          end
        end
        S_ADD: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) sum[4*i +: 4] <= add_res[3:0];
          end
          carry <= add_res[4];
          if (idx == LAST_IDX) begin
            // Index parks on the top digit rather than wrapping.
            state <= S_DONE;
            cout  <= add_res[4];
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed, table-driven bench for bcd_serial_add_ctrl (DIGITS=4 and DIGITS=1).
module tb_bcd_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        err;

  logic        clr1;
  logic        in_valid1;
  logic        in_ready1;
  logic [3:0]  a1;
  logic [3:0]  b1;
  logic        cin1;
  logic        out_valid1;
  logic        out_ready1;
  logic [3:0]  sum1;
  logic        cout1;
  logic        err1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .err(err)
  );

  bcd_serial_add_ctrl #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .err(err1)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        e;
  } vec_t;

  vec_t vt[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic no_valid(input int n, input string nm);
    int seen;
    seen = 0;
    repeat (n) begin
      step();
      if (out_valid) seen++;
    end
    chk(nm, seen, 0);
  endtask

  task automatic accept_op(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    // Scramble operands: the DUT must have latched them already.
    a = ~va; b = ~vb; cin = ~vc;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int lat;
    accept_op(v.a, v.b, v.cin);
    wait_valid(lat);
    chk($sformatf("v%0d latency", k), lat, 4);
    chk($sformatf("v%0d sum", k), sum, v.s);
    chk($sformatf("v%0d cout", k), cout, v.co);
    chk($sformatf("v%0d err", k), err, v.e);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk($sformatf("v%0d in_ready after", k), in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    vt[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    vt[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h4999, 16'h5000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[3] = '{16'h0008, 16'h0009, 1'b0, 16'h0017, 1'b0, 1'b0};
    vt[4] = '{16'h0006, 16'h0006, 1'b0, 16'h0012, 1'b0, 1'b0};
    vt[5] = '{16'h0005, 16'h0004, 1'b0, 16'h0009, 1'b0, 1'b0};
    vt[6] = '{16'h00A0, 16'h0001, 1'b0, 16'h0101, 1'b0, 1'b1};
    vt[7] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vt[8] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    vt[9] = '{16'hF000, 16'h0000, 1'b0, 16'h5000, 1'b1, 1'b1};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    clr1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) step();
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset sum", sum, 16'h0000);
    chk("reset cout", cout, 1'b0);
    chk("reset err", err, 1'b0);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 10; k++) run_vec(vt[k], k);

    // Backpressure: hold DONE for 5 cycles.
    accept_op(16'h1234, 16'h5678, 1'b0);
    wait_valid(lat);
    chk("bp latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp%0d out_valid", i), out_valid, 1'b1);
      chk($sformatf("bp%0d sum", i), sum, 16'h6912);
      chk($sformatf("bp%0d in_ready", i), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp release in_ready", in_ready, 1'b1);
    chk("bp release out_valid", out_valid, 1'b0);

    // Async reset during the second ADD cycle.
    accept_op(16'h1234, 16'h5678, 1'b0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst in_ready", in_ready, 1'b1);
    chk("midrst out_valid", out_valid, 1'b0);
    chk("midrst sum", sum, 16'h0000);
    chk("midrst cout", cout, 1'b0);
    step();
    rst_n = 1'b1;
    no_valid(8, "midrst no result");

    // clr during ADD.
    accept_op(16'h1234, 16'h5678, 1'b0);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr add in_ready", in_ready, 1'b1);
    no_valid(6, "clr add no result");

    // clr together with in_valid in IDLE: no accept.
    a = 16'h1111; b = 16'h2222; cin = 1'b0;
    in_valid = 1'b1; clr = 1'b1;
    step();
    in_valid = 1'b0; clr = 1'b0;
    chk("clr idle in_ready", in_ready, 1'b1);
    no_valid(6, "clr idle no result");

    // clr in DONE with out_ready low still ends the result.
    accept_op(16'h0002, 16'h0003, 1'b0);
    wait_valid(lat);
    chk("clr done sum", sum, 16'h0005);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr done out_valid", out_valid, 1'b0);
    chk("clr done in_ready", in_ready, 1'b1);

    // Single-digit instance: one ADD cycle.
    a1 = 4'h9; b1 = 4'h9; cin1 = 1'b1; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0; a1 = 4'h0; b1 = 4'h0; cin1 = 1'b0;
    chk("d1 busy out_valid", out_valid1, 1'b0);
    chk("d1 busy in_ready", in_ready1, 1'b0);
    step();
    chk("d1 out_valid", out_valid1, 1'b1);
    chk("d1 sum", sum1, 4'h9);
    chk("d1 cout", cout1, 1'b1);
    chk("d1 err", err1, 1'b0);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    chk("d1 in_ready after", in_ready1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
